seg_chase_sequencer: RTL and testbench

//  Controller for the 7-segment fade/chase datapath. Owns the step timer and the figure-8 position.

---
 rtl/seg_chase_sequencer_pkg.sv | 21 ++
 rtl/seg_chase_sequencer_if.sv | 30 +++
 rtl/seg_chase_sequencer_timer.sv | 36 +++
 rtl/seg_chase_sequencer.sv | 142 ++++++++++++++
 tb/tb_seg_chase_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_chase_sequencer_pkg.sv
// Shared types and constants for the 7-segment chase sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package seg_chase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    // Figure-8 walk: position -> segment index (a=0 .. g=6).
    // Entry 0 sits in the least significant bits.
    localparam logic [7:0][2:0] SEG_MAP = {3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0};

    function automatic logic [6:0] seg_onehot(input logic [2:0] p);
        seg_onehot = 7'd1 << SEG_MAP[p];
    endfunction

endpackage

// File: rtl/seg_chase_sequencer_if.sv
// Pin-side controls and datapath-side strobes of the chase sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; step_req/step_ack form a 4-phase handshake.
interface seg_chase_sequencer_if #(
    parameter int SPEED_WIDTH     = 3,
    parameter int PWM_PHASE_WIDTH = 5
);
    logic                       run;
    logic                       clear;
    logic                       step_req;
    logic                       step_ack;
    logic [SPEED_WIDTH-1:0]     speed;
    logic                       direction;
    logic                       bounce;
    logic [6:0]                 seg_hit;
    logic                       step_tick;
    logic                       fade_tick;
    logic [PWM_PHASE_WIDTH-1:0] pwm_phase;
    logic                       busy;

    modport master (
        output run, clear, step_req, speed, direction, bounce,
        input  step_ack, seg_hit, step_tick, fade_tick, pwm_phase, busy
    );

    modport slave (
        input  run, clear, step_req, speed, direction, bounce,
        output step_ack, seg_hit, step_tick, fade_tick, pwm_phase, busy
    );
endinterface

// File: rtl/seg_chase_sequencer_timer.sv
// Step timer: counts while enabled, flags terminal count and fade-zero points.
// Latency: wrap/low_zero are combinational from the current count.
// Backpressure: none; en freezes the count, clr forces it to zero.
module seg_step_timer #(
    parameter int COUNTER_WIDTH      = 23,
    parameter int FADE_COUNTER_WIDTH = 22,
    parameter int SPEED_WIDTH        = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic [SPEED_WIDTH-1:0] speed,
    output logic                   wrap,
    output logic                   low_zero
);
    logic [COUNTER_WIDTH-1:0] timer;
    logic [COUNTER_WIDTH-1:0] term;

    // Speed is the prefix of the terminal count; the low bits are all ones.
    assign term     = {speed, {(COUNTER_WIDTH-SPEED_WIDTH){1'b1}}};
    // >= so that lowering speed below the current count steps straight away.
    assign wrap     = (timer >= term);
    assign low_zero = (timer[FADE_COUNTER_WIDTH-1:0] == '0);

    // Free count with wrap to zero at terminal; clear wins over enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (en) begin
            timer <= wrap ? '0 : timer + COUNTER_WIDTH'(1);
        end
    end
endmodule

// File: rtl/seg_chase_sequencer.sv
// Chase controller: owns step timer, figure-8 position, step handshake and PWM phase.
// Latency: all outputs registered; seg_hit shows the new position one cycle after step_tick.
// Backpressure: none; single steps are acknowledged once per step_req high phase.
module seg_chase_sequencer
    import seg_chase_pkg::*;
#(
    parameter int COUNTER_WIDTH      = 23,
    parameter int FADE_COUNTER_WIDTH = 22,
    parameter int SPEED_WIDTH        = 3,
    parameter int PWM_PHASE_WIDTH    = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seg_chase_sequencer_if.slave  bus
);
    state_t                     state;
    logic [2:0]                 pos;
    logic                       eff_dir;
    logic                       step_armed;
    logic [PWM_PHASE_WIDTH-1:0] pwm;
    logic                       step_tick_q;
    logic                       step_ack_q;
    logic                       fade_tick_q;
    logic [6:0]                 seg_hit_q;
    logic                       busy_q;

    logic                       tmr_en;
    logic                       tmr_clr;
    logic                       wrap;
    logic                       low_zero;
    logic [2:0]                 adv_pos;
    logic                       adv_dir;

    // The timer only moves while actually running; IDLE and clear hold it at zero.
    assign tmr_en  = (state == ST_RUN) && bus.run && !bus.clear;
    assign tmr_clr = bus.clear || (state == ST_IDLE);

    seg_step_timer #(
        .COUNTER_WIDTH      (COUNTER_WIDTH),
        .FADE_COUNTER_WIDTH (FADE_COUNTER_WIDTH),
        .SPEED_WIDTH        (SPEED_WIDTH)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (tmr_en),
        .clr      (tmr_clr),
        .speed    (bus.speed),
        .wrap     (wrap),
        .low_zero (low_zero)
    );

    // Position/direction that one advance would produce (wrap or ping-pong).
    always_comb begin
        adv_pos = eff_dir ? pos + 3'd1 : pos - 3'd1;
        adv_dir = eff_dir;
        if (bus.bounce) begin
            if (eff_dir && pos == 3'd7) begin
                adv_pos = 3'd6;
                adv_dir = 1'b0;
            end else if (!eff_dir && pos == 3'd0) begin
                adv_pos = 3'd1;
                adv_dir = 1'b1;
            end
        end else begin
            adv_dir = bus.direction;
        end
    end

    // Sequencer FSM with position, step handshake and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pos         <= '0;
            eff_dir     <= 1'b1;
            step_armed  <= 1'b1;
            step_tick_q <= 1'b0;
            step_ack_q  <= 1'b0;
            fade_tick_q <= 1'b0;
            seg_hit_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            step_tick_q <= 1'b0;
            step_ack_q  <= 1'b0;
            fade_tick_q <= 1'b0;
            busy_q      <= 1'b0;
            seg_hit_q   <= (bus.clear || state == ST_IDLE) ? 7'd0 : seg_onehot(pos);
            if (!bus.bounce) eff_dir <= bus.direction;
            if (!bus.step_req) step_armed <= 1'b1;
            if (bus.clear) begin
                state <= ST_IDLE;
                pos   <= '0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_PAUSE: begin
                        if (bus.run) begin
                            state  <= ST_RUN;
                            busy_q <= 1'b1;
                        end else if (bus.step_req && step_armed) begin
                            state  <= ST_STEP;
                            busy_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!bus.run) begin
                            state <= ST_PAUSE;
                        end else begin
                            busy_q      <= 1'b1;
                            fade_tick_q <= low_zero;
                            if (wrap) begin
                                pos         <= adv_pos;
                                eff_dir     <= adv_dir;
                                step_tick_q <= 1'b1;
                            end
                        end
                    end
                    ST_STEP: begin
                        state       <= ST_PAUSE;
                        pos         <= adv_pos;
                        eff_dir     <= adv_dir;
                        step_tick_q <= 1'b1;
                        step_ack_q  <= 1'b1;
                        step_armed  <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // PWM phase runs in every state so paused LEDs keep their brightness.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pwm <= '0;
        else          pwm <= pwm + PWM_PHASE_WIDTH'(1);
    end

    assign bus.step_tick = step_tick_q;
    assign bus.step_ack  = step_ack_q;
    assign bus.fade_tick = fade_tick_q;
    assign bus.seg_hit   = seg_hit_q;
    assign bus.busy      = busy_q;
    assign bus.pwm_phase = pwm;
endmodule

// File: tb/tb_seg_chase_sequencer.sv
// Bench for the chase sequencer: cycle model plus directed scenarios.
// Latency: model predicts registered outputs one edge after the inputs.
// Backpressure: n/a.
module tb_seg_chase_sequencer;
    localparam int CW  = 6;
    localparam int FCW = 4;
    localparam int SW  = 3;
    localparam int PW  = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_STEP  = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seg_chase_sequencer_if #(.SPEED_WIDTH(SW), .PWM_PHASE_WIDTH(PW)) bus ();

    seg_chase_sequencer #(
        .COUNTER_WIDTH      (CW),
        .FADE_COUNTER_WIDTH (FCW),
        .SPEED_WIDTH        (SW),
        .PWM_PHASE_WIDTH    (PW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc_rel = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    string SEGS = "abgedcgf";
    int    mmode, mpos, mtimer, mpwm;
    bit    mdir, marmed, model_ok = 0;
    int    e_seg;
    bit    e_tick, e_ack, e_fade, e_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmode = M_IDLE; mpos = 0; mdir = 1; marmed = 1; mtimer = 0; mpwm = 0;
            e_seg = 0; e_tick = 0; e_ack = 0; e_fade = 0; e_busy = 0;
            model_ok = 1;
        end else begin
            int last;
            bit moving, was_step, old_dir;
            last     = (bus.speed + 1) * (1 << (CW - SW)) - 1;
            e_seg    = (bus.clear || mmode == M_IDLE) ? 0 : (1 << (SEGS.getc(mpos) - 97));
            e_tick   = 0; e_ack = 0; e_fade = 0; moving = 0;
            was_step = (mmode == M_STEP);
            old_dir  = mdir;
            if (bus.clear) begin
                mmode = M_IDLE; mpos = 0; mtimer = 0;
            end else if (mmode == M_IDLE || mmode == M_PAUSE) begin
                if (bus.run) mmode = M_RUN;
                else if (bus.step_req && marmed) mmode = M_STEP;
            end else if (mmode == M_RUN) begin
                if (!bus.run) mmode = M_PAUSE;
                else begin
                    e_fade = (mtimer % (1 << FCW) == 0);
                    if (mtimer >= last) begin mtimer = 0; moving = 1; end
                    else mtimer++;
                end
            end else begin
                moving = 1; e_ack = 1; mmode = M_PAUSE;
            end
            if (!bus.bounce) mdir = bus.direction;
            if (moving) begin
                e_tick = 1;
                if (bus.bounce && old_dir && mpos == 7) begin mpos = 6; mdir = 0; end
                else if (bus.bounce && !old_dir && mpos == 0) begin mpos = 1; mdir = 1; end
                else mpos = (mpos + (old_dir ? 1 : 7)) % 8;
            end
            marmed = (was_step && !bus.clear) ? 0 : (!bus.step_req ? 1 : marmed);
            e_busy = (mmode == M_RUN || mmode == M_STEP);
            mpwm   = (mpwm + 1) % (1 << PW);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_step_tick", bus.step_tick, e_tick);
            chk("m_step_ack",  bus.step_ack,  e_ack);
            chk("m_fade_tick", bus.fade_tick, e_fade);
            chk("m_seg_hit",   bus.seg_hit,   e_seg);
            chk("m_busy",      bus.busy,      e_busy);
            chk("m_pwm_phase", bus.pwm_phase, mpwm);
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_tick();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.step_tick && n < 300);
        if (!bus.step_tick) chk("tick_timeout", bus.step_tick, 1);
    endtask

    task automatic wait_fade();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.fade_tick && n < 300);
        if (!bus.fade_tick) chk("fade_timeout", bus.fade_tick, 1);
    endtask

    initial begin
        logic [6:0] exp1 [8];
        int last, n, acks, ticks;
        exp1 = '{7'h02, 7'h40, 7'h10, 7'h08, 7'h04, 7'h40, 7'h20, 7'h01};
        bus.run = 0; bus.clear = 0; bus.step_req = 0; bus.speed = '0;
        bus.direction = 1; bus.bounce = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", bus.seg_hit, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pwm", bus.pwm_phase, 0);
        reset_n = 1; cyc_rel = cyc;

        // 1: forward chase, speed 0 -> period 8
        bus.run = 1;
        repeat (3) @(negedge clk);
        chk("t1_seg_a", bus.seg_hit, 'h01);
        chk("t1_busy", bus.busy, 1);
        wait_tick(); last = cyc;
        @(negedge clk); chk("t1_seg0", bus.seg_hit, exp1[0]);
        for (int i = 1; i < 8; i++) begin
            wait_tick();
            chk("t1_gap", cyc - last, 8); last = cyc;
            @(negedge clk); chk("t1_seg", bus.seg_hit, exp1[i]);
        end

        // 2: reverse wrap 0->7, then bounce at 7
        bus.direction = 0;
        wait_tick(); @(negedge clk); chk("t2_rev_f", bus.seg_hit, 'h20);
        bus.direction = 1; @(negedge clk); bus.bounce = 1;
        wait_tick(); @(negedge clk); chk("t2_bounce_g", bus.seg_hit, 'h40);
        wait_tick(); @(negedge clk); chk("t2_bounce_c", bus.seg_hit, 'h04);
        bus.bounce = 0;

        // 3: slow speed, then cut below the running count
        wait_tick(); bus.speed = 3'd7; n = 0;
        repeat (40) begin @(negedge clk); n += bus.step_tick; end
        chk("t3_no_tick", n, 0);
        bus.speed = 3'd0;
        @(negedge clk); chk("t3_cut_tick", bus.step_tick, 1); last = cyc;
        wait_tick(); chk("t3_gap", cyc - last, 8);

        // 4: pause, PWM keeps running, single step with held request
        repeat (3) @(negedge clk);
        bus.run = 0; n = 0;
        repeat (10) begin @(negedge clk); n += bus.step_tick; end
        chk("t4_paused_ticks", n, 0);
        chk("t4_pwm", bus.pwm_phase, (cyc - cyc_rel) % 32);
        chk("t4_busy", bus.busy, 0);
        bus.step_req = 1; acks = 0; ticks = 0;
        repeat (20) begin @(negedge clk); acks += bus.step_ack; ticks += bus.step_tick; end
        chk("t4_acks", acks, 1);
        chk("t4_ticks", ticks, 1);
        bus.step_req = 0; @(negedge clk);

        // 5: clear beats step and run; async reset mid-run
        bus.clear = 1; bus.step_req = 1; bus.run = 1;
        @(negedge clk);
        chk("t5_seg", bus.seg_hit, 0);
        chk("t5_tick", bus.step_tick, 0);
        chk("t5_ack", bus.step_ack, 0);
        chk("t5_busy", bus.busy, 0);
        bus.clear = 0; bus.step_req = 0; bus.run = 0;
        @(negedge clk); chk("t5_idle_seg", bus.seg_hit, 0);
        bus.run = 1;
        repeat (20) @(negedge clk);
        @(posedge clk); #2 reset_n = 0; #1;
        chk("t5_rst_seg", bus.seg_hit, 0);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_pwm", bus.pwm_phase, 0);
        chk("t5_rst_tick", bus.step_tick, 0);
        chk("t5_rst_fade", bus.fade_tick, 0);
        @(negedge clk); bus.speed = 3'd7; reset_n = 1; cyc_rel = cyc;

        // 6: fade spacing 16, none paused, PWM wrap
        wait_fade(); last = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_fade(); chk("t6_fade_gap", cyc - last, 16); last = cyc;
        end
        bus.run = 0; n = 0;
        repeat (40) begin @(negedge clk); n += bus.fade_tick; end
        chk("t6_paused_fade", n, 0);
        n = 0;
        while (bus.pwm_phase != 5'd31 && n < 40) begin @(negedge clk); n++; end
        chk("t6_pwm31", bus.pwm_phase, 31);
        @(negedge clk); chk("t6_pwm_wrap", bus.pwm_phase, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
